// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the mode-0 SPI responder
package spi_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // Levels the pad synchronizers hold while in reset (bus idle)
    localparam logic CS_IDLE   = 1'b1;
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - pad synchronizer with registered rise/fall pulses
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_l,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    assign level = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            prev <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= (sync << 1) | SYNC_STAGES'(din);
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
            fall <= ~sync[SYNC_STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled mode-0 SPI responder with one-deep tx holding buffer
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              SPI_Clk,
    input  logic              SPI_CS,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              SPI_MISO_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic sck_rise, sck_fall, sck_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sync_sck (
        .clk     (clk),
        .reset_l (reset_l),
        .din     (SPI_Clk),
        .level   (sck_level_unused),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_sync_cs (
        .clk     (clk),
        .reset_l (reset_l),
        .din     (SPI_CS),
        .level   (cs_level_unused),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_mosi (
        .clk     (clk),
        .reset_l (reset_l),
        .din     (SPI_MOSI),
        .level   (mosi_level),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    spi_state_t         state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  rx_shift;
    logic [DATA_W-1:0]  tx_shift;
    logic [DATA_W-1:0]  tx_buf;
    logic               buf_full;
    logic               skip_fall;
    logic               last_bit;
    logic               boundary;

    always_comb begin
        last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
        boundary = 1'b0;
        if (state == IDLE)
            boundary = cs_fall;
        else
            boundary = !cs_rise && sck_rise && last_bit;
    end

    assign tx_ready = ~buf_full;
    assign SPI_MISO = SPI_MISO_oe & tx_shift[DATA_W-1];

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            buf_full    <= 1'b0;
            skip_fall   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            SPI_MISO_oe <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            // An empty buffer always accepts, even on a frame boundary
            if (tx_load && !buf_full) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state       <= ACTIVE;
                        SPI_MISO_oe <= 1'b1;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        skip_fall   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        SPI_MISO_oe <= 1'b0;
                        busy        <= 1'b0;
                        bit_cnt     <= '0;
                        rx_shift    <= '0;
                        skip_fall   <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[DATA_W-2:0], mosi_level};
                        if (last_bit) begin
                            bit_cnt   <= '0;
                            rx_data   <= {rx_shift[DATA_W-2:0], mosi_level};
                            rx_valid  <= 1'b1;
                            skip_fall <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            skip_fall <= 1'b0;
                        end
                    end else if (sck_fall) begin
                        // The fall right after a boundary must keep the freshly loaded MSB
                        if (skip_fall)
                            skip_fall <= 1'b0;
                        else
                            tx_shift <= tx_shift << 1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (boundary) begin
                if (buf_full) begin
                    tx_shift <= tx_buf;
                    buf_full <= 1'b0;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       SPI_Clk = 1'b0;
    logic       SPI_CS = 1'b1;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic       SPI_MISO_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic       tx_underrun;
    logic       busy;

    spi_slave dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .SPI_Clk     (SPI_Clk),
        .SPI_CS      (SPI_CS),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_oe (SPI_MISO_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int rx_cnt = 0;
    int udr_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rx_valid pops one expected byte
    always @(negedge clk) begin
        if (tx_underrun === 1'b1) udr_cnt++;
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            check("rx_latency", cyc - last_rise_cyc, 4);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected actual=0x%0h expected=none", rx_data);
            end else begin
                check("rx_data", rx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        wait_cycles(1);
        tx_load = 1'b0;
    endtask

    task automatic cs_low();
        SPI_CS = 1'b0;
        wait_cycles(5);
    endtask

    task automatic cs_high();
        wait_cycles(4);
        SPI_CS = 1'b1;
        wait_cycles(6);
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = mo[7-i];
            wait_cycles(4);
            SPI_Clk = 1'b1;
            last_rise_cyc = cyc;
            mi = {mi[6:0], SPI_MISO};
            wait_cycles(4);
            SPI_Clk = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},     SPI_MISO,    0);
        check({tag, "_oe"},       SPI_MISO_oe, 0);
        check({tag, "_rx_data"},  rx_data,     0);
        check({tag, "_rx_valid"}, rx_valid,    0);
        check({tag, "_tx_ready"}, tx_ready,    1);
        check({tag, "_underrun"}, tx_underrun, 0);
        check({tag, "_busy"},     busy,        0);
    endtask

    typedef struct {
        logic [7:0] mosi;
        logic       preload;
        logic [7:0] tx;
        logic [7:0] exp_miso;
        int         exp_udr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] mi;
        int r0;
        int u0;

        vecs[0] = '{8'hA5, 1'b0, 8'h00, 8'h00, 1};
        vecs[1] = '{8'hC3, 1'b1, 8'h3C, 8'h3C, 0};
        vecs[2] = '{8'h00, 1'b1, 8'hFF, 8'hFF, 0};
        vecs[3] = '{8'hFF, 1'b1, 8'h81, 8'h81, 0};

        wait_cycles(3);
        check_reset_outputs("in_reset");
        reset_l = 1'b1;
        wait_cycles(3);
        check_reset_outputs("after_reset");

        foreach (vecs[k]) begin
            if (vecs[k].preload) begin
                load_tx(vecs[k].tx);
                check("vec_tx_ready_loaded", tx_ready, 0);
            end
            u0 = udr_cnt;
            r0 = rx_cnt;
            exp_q.push_back(vecs[k].mosi);
            cs_low();
            check("vec_busy", busy, 1);
            check("vec_oe", SPI_MISO_oe, 1);
            check("vec_tx_ready_start", tx_ready, 1);
            check("vec_underrun_start", udr_cnt - u0, vecs[k].exp_udr);
            spi_bits(vecs[k].mosi, 8, mi);
            check("vec_miso", mi, vecs[k].exp_miso);
            cs_high();
            check("vec_rx_count", rx_cnt - r0, 1);
            check("vec_rx_data", rx_data, vecs[k].mosi);
            check("vec_busy_end", busy, 0);
            check("vec_oe_end", SPI_MISO_oe, 0);
        end

        // Back-to-back frames; second load while full must be ignored
        r0 = rx_cnt;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        cs_low();
        load_tx(8'h56);
        check("b2b_tx_ready", tx_ready, 0);
        load_tx(8'h99);
        spi_bits(8'h12, 8, mi);
        check("b2b_miso0", mi, 8'h00);
        spi_bits(8'h34, 8, mi);
        check("b2b_miso1", mi, 8'h56);
        cs_high();
        check("b2b_rx_count", rx_cnt - r0, 2);
        check("b2b_rx_data", rx_data, 8'h34);

        // CS abort after 5 bits
        r0 = rx_cnt;
        cs_low();
        spi_bits(8'hFF, 5, mi);
        cs_high();
        check("abort_no_rx", rx_cnt - r0, 0);
        check("abort_busy", busy, 0);
        exp_q.push_back(8'h81);
        cs_low();
        spi_bits(8'h81, 8, mi);
        cs_high();
        check("abort_next_rx_count", rx_cnt - r0, 1);
        check("abort_next_rx_data", rx_data, 8'h81);

        // Reset mid-frame
        load_tx(8'hAA);
        cs_low();
        load_tx(8'h77);
        check("rst_buf_full", tx_ready, 0);
        spi_bits(8'hC0, 3, mi);
        r0 = rx_cnt;
        reset_l = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        SPI_CS = 1'b1;
        wait_cycles(3);
        reset_l = 1'b1;
        wait_cycles(3);
        check("rst_no_rx", rx_cnt - r0, 0);
        exp_q.push_back(8'h5A);
        cs_low();
        spi_bits(8'h5A, 8, mi);
        cs_high();
        check("rst_next_rx_count", rx_cnt - r0, 1);
        check("rst_next_rx_data", rx_data, 8'h5A);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
